// File: rtl/mc6809_dma_arb.sv
// MC6809 DMA bus arbiter: BA/BS handshake, round-robin grant, capped bursts.
// Define MC6809_DMA_ARB_WDOG_EN to build the REQ-phase watchdog and err flag.
module mc6809_dma_arb #(
  parameter int NREQ     = 2,
  parameter int BURST    = 14,
  parameter int WDOG_CYC = 64
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      owner,
  input  logic            BA,
  input  logic            BS,
  output logic            nDMABREQ,
  output logic            busy,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETTLE,
    GRANT,
    RELEASE
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [2:0]      ptr;
  logic [2:0]      owner_d;
  logic [2:0]      win;
  logic [2:0]      idx;
  logic            found;
  logic            wdog_trip;
  logic [7:0]      req8;
  logic [3:0]      cnt;
  logic [3:0]      cnt_d;
  logic [NREQ-1:0] grant_d;

  assign req8 = 8'(req);

  // Walk forward from the last grantee; first active bit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = (idx == 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
      if (!found && req8[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (|req) state_d = REQ;
      end
      REQ: begin
        if (BA && BS) begin
          state_d = SETTLE;
        end else if (!(|req) || wdog_trip) begin
          state_d = RELEASE;
        end
      end
      SETTLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = win;
          cnt_d   = '0;
        end else begin
          state_d = RELEASE;
        end
      end
      GRANT: begin
        if (cnt != 4'(BURST)) cnt_d = cnt + 4'd1;
        if (!req8[owner] || cnt == 4'(BURST - 1)) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!BA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      grant_d[i] = (state_d == GRANT) && (owner_d == 3'(i));
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      ptr      <= 3'(NREQ - 1);
      owner    <= '0;
      cnt      <= '0;
      grant    <= '0;
      nDMABREQ <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      cnt      <= cnt_d;
      grant    <= grant_d;
      nDMABREQ <= (state_d == IDLE) || (state_d == RELEASE);
      busy     <= (state_d != IDLE);
      if (state == SETTLE && found) ptr <= win;
    end
  end

`ifdef MC6809_DMA_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);

  logic [WW-1:0] wcnt;

  assign wdog_trip = (wcnt == WW'(WDOG_CYC - 1));

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      wcnt <= (state == REQ) ? wcnt + WW'(1) : '0;
      if (state == REQ && !(BA && BS) && wdog_trip) err <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  // WDOG_CYC only matters in the watchdog build; err is constant 0 here.
  assign err = (WDOG_CYC < 0);
`endif

endmodule
